// File: rtl/ws_array_if.sv
// Control/status bundle between a tile requester and the weight-stationary array sequencer.
// The requester drives start/skip_wload/num_vec; the sequencer drives everything else.
interface ws_array_if #(
    parameter int ROWS  = 4,
    parameter int VEC_W = 8
) ();
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             start;
    logic             skip_wload;
    logic [VEC_W-1:0] num_vec;
    logic             busy;
    logic             done;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic             weight_wen;
    logic             act_rd_en;
    logic [VEC_W-1:0] act_rd_addr;
    logic [ROWS-1:0]  out_valid;

    modport master (
        output start, skip_wload, num_vec,
        input  busy, done, w_rd_en, w_rd_addr, weight_wen,
               act_rd_en, act_rd_addr, out_valid
    );

    modport slave (
        input  start, skip_wload, num_vec,
        output busy, done, w_rd_en, w_rd_addr, weight_wen,
               act_rd_en, act_rd_addr, out_valid
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// Tile sequencer for a weight-stationary MAC systolic array: weight shift-load,
// activation streaming, pipeline drain, and per-row result-valid strobes.
module ws_array_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int VEC_W   = 8,
    parameter int OUT_LAT = 5
) (
    input logic       clk,
    input logic       rst_n,
    ws_array_if.slave bus
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LW = $clog2(ROWS + 1);
    localparam int DL = OUT_LAT + ROWS - 1;
    localparam int DW = $clog2(DL + 1);

    localparam logic [LW-1:0]    ROWS_L   = LW'(ROWS);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DL - 1);
    localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t           state_reg, state_next;
    logic [LW-1:0]    load_cnt_reg, load_cnt_next;
    logic [VEC_W-1:0] vec_cnt_reg, vec_cnt_next;
    logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
    logic [VEC_W-1:0] num_vec_reg, num_vec_next;
    logic [DL-1:0]    dly_reg;

    logic             busy_c;
    logic             done_c;
    logic             w_rd_en_c;
    logic [AW-1:0]    w_rd_addr_c;
    logic             weight_wen_c;
    logic             act_rd_en_c;
    logic [VEC_W-1:0] act_rd_addr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            load_cnt_reg  <= '0;
            vec_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            num_vec_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            load_cnt_reg  <= load_cnt_next;
            vec_cnt_reg   <= vec_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            num_vec_reg   <= num_vec_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_cnt_next  = load_cnt_reg;
        vec_cnt_next   = vec_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        num_vec_next   = num_vec_reg;
        busy_c         = 1'b0;
        done_c         = 1'b0;
        w_rd_en_c      = 1'b0;
        w_rd_addr_c    = '0;
        weight_wen_c   = 1'b0;
        act_rd_en_c    = 1'b0;
        // Address stays on the last used index between reads so it never goes X.
        act_rd_addr_c  = vec_cnt_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    num_vec_next   = bus.num_vec;
                    load_cnt_next  = '0;
                    vec_cnt_next   = '0;
                    drain_cnt_next = '0;
                    if (!bus.skip_wload)
                        state_next = S_LOAD;
                    else if (bus.num_vec == '0)
                        state_next = S_FIN;
                    else
                        state_next = S_COMPUTE;
                end
            end

            S_LOAD: begin
                busy_c = 1'b1;
                // Bottom row is read first; the shift enable trails the read by the buffer latency.
                if (load_cnt_reg < ROWS_L) begin
                    w_rd_en_c   = 1'b1;
                    w_rd_addr_c = AW'(ROWS_L - LW'(1) - load_cnt_reg);
                end
                weight_wen_c = (load_cnt_reg != '0);
                if (load_cnt_reg == ROWS_L) begin
                    state_next = (num_vec_reg == '0) ? S_FIN : S_COMPUTE;
                end else begin
                    load_cnt_next = load_cnt_reg + LW'(1);
                end
            end

            S_COMPUTE: begin
                busy_c      = 1'b1;
                act_rd_en_c = 1'b1;
                // Compare against num_vec-1 so a full-range count never needs a wider counter.
                if (vec_cnt_reg == num_vec_reg - VEC_ONE) begin
                    state_next     = S_DRAIN;
                    drain_cnt_next = '0;
                end else begin
                    vec_cnt_next = vec_cnt_reg + VEC_ONE;
                end
            end

            S_DRAIN: begin
                busy_c = 1'b1;
                if (drain_cnt_reg == DRAIN_LAST)
                    state_next = S_FIN;
                else
                    drain_cnt_next = drain_cnt_reg + DW'(1);
            end

            S_FIN: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Delay line: bit i holds act_rd_en from i+1 cycles ago.
    generate
        for (genvar gi = 0; gi < DL; gi++) begin : g_dly
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dly_reg[gi] <= 1'b0;
                else if (gi == 0)
                    dly_reg[gi] <= act_rd_en_c;
                else
                    dly_reg[gi] <= dly_reg[(gi > 0) ? gi - 1 : 0];
            end
        end

        for (genvar gi = 0; gi < ROWS; gi++) begin : g_out_valid
            assign bus.out_valid[gi] = dly_reg[OUT_LAT + gi - 1];
        end
    endgenerate

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.w_rd_en     = w_rd_en_c;
    assign bus.w_rd_addr   = w_rd_addr_c;
    assign bus.weight_wen  = weight_wen_c;
    assign bus.act_rd_en   = act_rd_en_c;
    assign bus.act_rd_addr = act_rd_addr_c;

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Directed bench for ws_array_ctrl: per-cycle expectations are queued when a tile is
// started and popped/compared on the falling edge while the tile runs.
module tb_ws_array_ctrl;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int VEC_W   = 8;
    localparam int OUT_LAT = 5;
    localparam int AW      = 2;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             w_rd_en;
        logic [AW-1:0]    w_rd_addr;
        logic             weight_wen;
        logic             act_rd_en;
        logic [VEC_W-1:0] act_rd_addr;
        logic [ROWS-1:0]  out_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    ws_array_if #(.ROWS(ROWS), .VEC_W(VEC_W)) bus ();

    ws_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W), .OUT_LAT(OUT_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int c, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, expv);
        end
    endtask

    function automatic int load_len(bit skip);
        return skip ? 0 : ROWS + 1;
    endfunction

    function automatic int fin_cycle(int nv, bit skip);
        if (nv == 0) return load_len(skip) + 1;
        return load_len(skip) + nv + (OUT_LAT + ROWS - 1) + 1;
    endfunction

    // Expected outputs c cycles after the cycle in which start was sampled.
    function automatic exp_t expect_at(int c, int nv, bit skip);
        exp_t e;
        int   l   = load_len(skip);
        int   fin = fin_cycle(nv, skip);
        e = '0;
        e.busy = (c >= 1 && c <= fin);
        e.done = (c == fin);
        if (!skip && c >= 1 && c <= ROWS) begin
            e.w_rd_en   = 1'b1;
            e.w_rd_addr = AW'(ROWS - c);
        end
        e.weight_wen = (!skip && c >= 2 && c <= ROWS + 1);
        if (nv > 0 && c >= l + 1 && c <= l + nv) begin
            e.act_rd_en   = 1'b1;
            e.act_rd_addr = VEC_W'(c - l - 1);
        end
        for (int r = 0; r < ROWS; r++)
            e.out_valid[r] = (nv > 0 && c >= l + 1 + OUT_LAT + r && c <= l + nv + OUT_LAT + r);
        return e;
    endfunction

    task automatic compare_cycle(int c);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", c, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("busy", c, 32'(bus.busy), 32'(e.busy));
        check("done", c, 32'(bus.done), 32'(e.done));
        check("w_rd_en", c, 32'(bus.w_rd_en), 32'(e.w_rd_en));
        check("weight_wen", c, 32'(bus.weight_wen), 32'(e.weight_wen));
        check("act_rd_en", c, 32'(bus.act_rd_en), 32'(e.act_rd_en));
        check("out_valid", c, 32'(bus.out_valid), 32'(e.out_valid));
        if (e.w_rd_en) check("w_rd_addr", c, 32'(bus.w_rd_addr), 32'(e.w_rd_addr));
        if (e.act_rd_en) check("act_rd_addr", c, 32'(bus.act_rd_addr), 32'(e.act_rd_addr));
        check("addr_known", c, 32'($isunknown({bus.w_rd_addr, bus.act_rd_addr})), 32'd0);
        check("wen_overlap", c,
              32'(bus.weight_wen & (bus.act_rd_en | (|bus.out_valid))), 32'd0);
    endtask

    task automatic check_all_zero(string tag, int c);
        check(tag, c, 32'({bus.busy, bus.done, bus.w_rd_en, bus.weight_wen, bus.act_rd_en,
                           bus.out_valid, bus.w_rd_addr, bus.act_rd_addr}), 32'd0);
    endtask

    // Entered and left at a falling edge; cycle 0 is the IDLE cycle that samples start.
    task automatic run_tile(int nv, bit skip, bit hold, int pulse_a, int pulse_b,
                            int abort_at, int tail);
        int last = fin_cycle(nv, skip) + tail;
        for (int c = 0; c <= last; c++)
            exp_q.push_back(expect_at(c, nv, skip));
        $display("tile: num_vec=%0d skip_wload=%0d hold=%0d expected done at cycle %0d",
                 nv, skip, hold, fin_cycle(nv, skip));
        for (int c = 0; c <= last; c++) begin
            bus.start      = (c == 0) || hold || (c == pulse_a) || (c == pulse_b);
            bus.skip_wload = (c == 0) ? skip : ~skip;
            bus.num_vec    = (c == 0) ? VEC_W'(nv) : VEC_W'(nv + 7);
            compare_cycle(c);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("async_reset_outputs", c);
                exp_q.delete();
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.skip_wload = 1'b0;
        bus.num_vec    = '0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state", 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset", 0);

        // Full tile with weight load.
        run_tile(3, 1'b0, 1'b0, -1, -1, -1, 2);
        // Resident weights reused.
        run_tile(2, 1'b1, 1'b0, -1, -1, -1, 2);
        // Empty tile: load only.
        run_tile(0, 1'b0, 1'b0, -1, -1, -1, 2);
        // Empty tile with skip: straight to FIN.
        run_tile(0, 1'b1, 1'b0, -1, -1, -1, 2);
        // start pulses in COMPUTE (cycle 7) and DRAIN (cycle 12) are ignored.
        run_tile(3, 1'b0, 1'b0, 7, 12, -1, 2);

        // Reset dropped mid-COMPUTE; done must never appear.
        run_tile(3, 1'b0, 1'b0, -1, -1, 7, 0);
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_all_zero("held_in_reset", i);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_tile(3, 1'b0, 1'b0, -1, -1, -1, 2);

        // Back-to-back tiles with start held high.
        run_tile(3, 1'b0, 1'b1, -1, -1, -1, 0);
        run_tile(2, 1'b1, 1'b1, -1, -1, -1, 0);
        run_tile(1, 1'b0, 1'b0, -1, -1, -1, 2);

        // Largest vector count must run the full length without wrapping.
        run_tile(255, 1'b1, 1'b0, -1, -1, -1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ws_array_ctrl.md
Name: ws_array_ctrl

Overview:
- Sequencer for the weight-stationary MAC systolic array: ROWS x COLS PEs, weight column-shift load, activations flowing down columns, partial sums flowing across rows.
- Runs one tile per `start`: weight preload (optional), then activation streaming, then pipeline drain.
- Drives the weight-buffer read, the array-wide `weight_wen`, the activation-buffer read, and per-row output-valid strobes for the result collector.

Parameters:
- ROWS, 4, PE rows in the array; also the number of weight words shifted per load.
- COLS, 4, PE columns; informational only, kept for checks and assertions.
- VEC_W, 8, width of the activation-vector count and activation address.
- OUT_LAT, 5, cycles from `act_rd_en` of vector j to that vector's row-0 result at the array edge (covers buffer latency, skew and array depth). Must be >= 1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset.
- start, input, 1, tile start request.
- skip_wload, input, 1, reuse the resident weights and skip the load phase.
- num_vec, input, VEC_W, number of activation vectors in the tile.
- busy, output, 1, tile in progress.
- done, output, 1, one-cycle tile-complete pulse.
- w_rd_en, output, 1, weight-buffer read strobe (1-cycle read latency).
- w_rd_addr, output, clog2(ROWS), weight row address.
- weight_wen, output, 1, array weight-shift enable.
- act_rd_en, output, 1, activation-buffer read strobe.
- act_rd_addr, output, VEC_W, activation vector index.
- out_valid, output, ROWS, per-row result-valid strobes.

Interface fixed facts:
- One clock, `clk`.
- Reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, all counters and the delay line are cleared.
  - Reset asserted mid-tile aborts immediately; no `done` is produced.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, FIN.
- IDLE:
  - `start` = 1 latches `num_vec` and `skip_wload`.
  - Next state is LOAD, or COMPUTE when `skip_wload` = 1.
  - `start` in any other state is ignored.
- busy: 1 in every state except IDLE, including the FIN cycle.
- LOAD lasts ROWS+1 cycles, indexed k = 0..ROWS.
  - k < ROWS: `w_rd_en` = 1, `w_rd_addr` = ROWS-1-k (bottom row first).
  - k >= 1: `weight_wen` = 1. It is therefore high for exactly ROWS consecutive cycles, one cycle behind `w_rd_en`.
  - After k = ROWS: go to COMPUTE, or to FIN when latched num_vec = 0.
- skip_wload with num_vec = 0: go straight to FIN.
- Hard rule: `weight_wen` is never 1 in the same cycle as `act_rd_en`, nor while any delay-line bit is set.
- COMPUTE lasts num_vec cycles.
  - `act_rd_en` = 1 throughout.
  - `act_rd_addr` = 0, 1, ..., num_vec-1.
  - Then go to DRAIN.
- out_valid generation:
  - A shift line of length OUT_LAT+ROWS-1 is fed by `act_rd_en`.
  - `out_valid[r]` = `act_rd_en` delayed by OUT_LAT+r cycles.
  - Result: row r is high for num_vec consecutive cycles starting OUT_LAT+r cycles after the first `act_rd_en`.
- DRAIN lasts exactly OUT_LAT+ROWS-1 cycles, then FIN.
  - The last `out_valid[ROWS-1]` cycle is the final DRAIN cycle.
- FIN lasts 1 cycle: `done` = 1, then IDLE. A new `start` is accepted from the next cycle.
- Counters:
  - The load counter is clog2(ROWS+1) bits.
  - The vector counter is VEC_W bits; num_vec = 2^VEC_W-1 must not wrap early.
  - The drain counter is sized for OUT_LAT+ROWS-1.
- The `act_rd_addr` and `w_rd_addr` values are don't-care when their enables are 0, but must be held stable (no X).

Test Plan:
1. Full tile, ROWS=4, OUT_LAT=5, num_vec=3, skip_wload=0, start at cycle 0:
   - `w_rd_en` cycles 1-4 with addr 3,2,1,0; `weight_wen` cycles 2-5.
   - `act_rd_en` cycles 6-8 with addr 0,1,2.
   - `out_valid[0]` cycles 11-13, `out_valid[3]` cycles 14-16.
   - `done` at cycle 17; `busy` cycles 1-17.
2. skip_wload=1, num_vec=2:
   - No `w_rd_en` or `weight_wen`.
   - `act_rd_en` cycles 1-2, `done` at cycle 2+5+3+1 = 11.
3. num_vec=0, skip_wload=0: LOAD only, `done` at cycle 6, `out_valid` never set.
4. `start` pulsed during COMPUTE and DRAIN: ignored, and the tile timing is identical to scenario 1.
5. `rst_n` dropped at cycle 7 of scenario 1:
   - All outputs are 0 asynchronously and `done` is never seen.
   - After release, a fresh `start` reproduces scenario 1 timing.
6. Back-to-back tiles: `start` held high continuously.
   - The second tile begins the cycle after FIN.
   - Check that `weight_wen` never overlaps `act_rd_en` or any set `out_valid`.
